// File: rtl/scoreboard_ctrl.sv
// Basketball scoreboard control core: game clock, shot clock, periods, saturating
// scores, release-detected buttons and horn timer. Binary outputs only.
module scoreboard_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned SCAN_DIV    = 50_000,
    parameter int unsigned PERIOD_MIN  = 10,
    parameter int unsigned NUM_PERIODS = 4,
    parameter int unsigned SHOT_SEC    = 24,
    parameter int unsigned SCORE_MAX   = 199,
    parameter int unsigned HORN_CYC    = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic [2:0] btn_pts,
    input  logic       btn_shot,
    input  logic       sel_team,
    input  logic       sel_sub,
    output logic [6:0] min_o,
    output logic [5:0] sec_o,
    output logic [5:0] shot_o,
    output logic [2:0] period_o,
    output logic [7:0] score_a,
    output logic [7:0] score_b,
    output logic       running,
    output logic [1:0] state_o,
    output logic       horn
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned HW = (HORN_CYC > 0) ? $clog2(HORN_CYC + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HORN_LOAD   = HW'(HORN_CYC);
    localparam logic [6:0]    MIN_LOAD    = 7'(PERIOD_MIN);
    localparam logic [5:0]    SHOT_LOAD   = 6'(SHOT_SEC);
    localparam logic [2:0]    LAST_PERIOD = 3'(NUM_PERIODS);
    localparam logic [7:0]    SCORE_LIM   = 8'(SCORE_MAX);

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_RUN      = 2'd1,
        ST_PER_END  = 2'd2,
        ST_GAME_END = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [4:0]    smp_cur_q, smp_cur_d;
    logic [4:0]    smp_prev_q, smp_prev_d;
    logic          smp_vld_q, smp_vld_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] horn_cnt_q, horn_cnt_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    shot_q, shot_d;
    logic [2:0]    period_q, period_d;
    logic [7:0]    score_a_q, score_a_d;
    logic [7:0]    score_b_q, score_b_d;

    logic          scan_tc;
    logic [4:0]    rel;
    logic          rel_run, rel_shot;
    logic [1:0]    pts_n;
    logic          tick, horn_evt;
    logic [6:0]    dec_min;
    logic [5:0]    dec_sec, dec_shot;

    function automatic logic [7:0] apply_pts(input logic [7:0] s, input logic [1:0] n,
                                             input logic sub);
        logic [8:0] sum;
        sum = {1'b0, s} + {7'b0, n};
        if (sub)
            return (s < {6'b0, n}) ? 8'd0 : s - {6'b0, n};
        return (sum > {1'b0, SCORE_LIM}) ? SCORE_LIM : sum[7:0];
    endfunction

    // Button vector layout: [4]=run, [3]=shot, [2:0]=points.
    always_comb begin : scan_comb
        scan_tc    = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d = scan_tc ? '0 : scan_cnt_q + SW'(1);
        smp_cur_d  = smp_cur_q;
        smp_prev_d = smp_prev_q;
        if (scan_tc) begin
            smp_prev_d = smp_cur_q;
            smp_cur_d  = {btn_run, btn_shot, btn_pts};
        end
        smp_vld_d = scan_tc;
        rel       = smp_vld_q ? (smp_prev_q & ~smp_cur_q) : '0;
        rel_run   = rel[4];
        rel_shot  = rel[3];
    end

    always_comb begin : score_comb
        pts_n     = 2'd0;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        if (rel[2])      pts_n = 2'd3;
        else if (rel[1]) pts_n = 2'd2;
        else if (rel[0]) pts_n = 2'd1;
        if (pts_n != 2'd0) begin
            if (sel_team) score_a_d = apply_pts(score_a_q, pts_n, sel_sub);
            else          score_b_d = apply_pts(score_b_q, pts_n, sel_sub);
        end
    end

    always_comb begin : fsm_comb
        state_d  = state_q;
        min_d    = min_q;
        sec_d    = sec_q;
        shot_d   = shot_q;
        period_d = period_q;
        horn_evt = 1'b0;
        tick     = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);

        if (sec_q == '0) begin
            dec_sec = 6'd59;
            dec_min = min_q - 7'd1;
        end else begin
            dec_sec = sec_q - 6'd1;
            dec_min = min_q;
        end
        dec_shot = (shot_q != '0) ? shot_q - 6'd1 : '0;

        case (state_q)
            ST_STOP: begin
                if (rel_run) begin
                    state_d = ST_RUN;
                    if (shot_q == '0) shot_d = SHOT_LOAD;
                end
                if (rel_shot) shot_d = SHOT_LOAD;
            end
            ST_RUN: begin
                // A stop release discards a coincident tick; a shot reload overrides it.
                if (rel_run) begin
                    state_d = ST_STOP;
                end else if (tick) begin
                    min_d  = dec_min;
                    sec_d  = dec_sec;
                    shot_d = dec_shot;
                    if (dec_min == '0 && dec_sec == '0) begin
                        state_d  = (period_q == LAST_PERIOD) ? ST_GAME_END : ST_PER_END;
                        horn_evt = 1'b1;
                    end else if (dec_shot == '0 && !rel_shot) begin
                        state_d  = ST_STOP;
                        horn_evt = 1'b1;
                    end
                end
                if (rel_shot) shot_d = SHOT_LOAD;
            end
            ST_PER_END: begin
                if (rel_run) begin
                    state_d  = ST_RUN;
                    min_d    = MIN_LOAD;
                    sec_d    = '0;
                    shot_d   = SHOT_LOAD;
                    period_d = period_q + 3'd1;
                end
                if (rel_shot) shot_d = SHOT_LOAD;
            end
            ST_GAME_END: begin
                state_d = ST_GAME_END;
            end
        endcase

        horn_cnt_d = horn_evt ? HORN_LOAD
                   : (horn_cnt_q != '0) ? horn_cnt_q - HW'(1) : '0;
        tick_cnt_d = (state_q == ST_RUN && state_d == ST_RUN && !tick)
                   ? tick_cnt_q + TW'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STOP;
            scan_cnt_q <= '0;
            smp_cur_q  <= '0;
            smp_prev_q <= '0;
            smp_vld_q  <= 1'b0;
            tick_cnt_q <= '0;
            horn_cnt_q <= '0;
            min_q      <= MIN_LOAD;
            sec_q      <= '0;
            shot_q     <= SHOT_LOAD;
            period_q   <= 3'd1;
            score_a_q  <= '0;
            score_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            smp_cur_q  <= smp_cur_d;
            smp_prev_q <= smp_prev_d;
            smp_vld_q  <= smp_vld_d;
            tick_cnt_q <= tick_cnt_d;
            horn_cnt_q <= horn_cnt_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            shot_q     <= shot_d;
            period_q   <= period_d;
            score_a_q  <= score_a_d;
            score_b_q  <= score_b_d;
        end
    end

    assign min_o    = min_q;
    assign sec_o    = sec_q;
    assign shot_o   = shot_q;
    assign period_o = period_q;
    assign score_a  = score_a_q;
    assign score_b  = score_b_q;
    assign running  = (state_q == ST_RUN);
    assign state_o  = state_q;
    assign horn     = (horn_cnt_q != '0);

endmodule

// File: doc/scoreboard_ctrl.md
Name: scoreboard_ctrl

Overview:
Parametrised game-control core for the basketball scoreboard. It covers the game clock (min:sec), a shot clock, period counting and two team scores, with button release detection and a horn output. Scores saturate instead of wrapping. It outputs binary values only; the existing BCD converters and the 7-segment multiplexer sit downstream.

Parameters:
TICK_DIV, 50_000_000, clk cycles per game-clock second
SCAN_DIV, 50_000, clk cycles per button sample (1 kHz at 50 MHz)
PERIOD_MIN, 10, minutes per period (1..99)
NUM_PERIODS, 4, periods per game (1..7)
SHOT_SEC, 24, shot-clock reload value (1..63)
SCORE_MAX, 199, score saturation limit (≤255)
HORN_CYC, 25_000_000, horn duration in clk cycles

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
btn_run  in  1  start/stop, acts on release
btn_pts  in  3  [0]=1 pt, [1]=2 pt, [2]=3 pt, act on release
btn_shot  in  1  shot-clock reload, acts on release
sel_team  in  1  1=team A, 0=team B
sel_sub  in  1  1=subtract, 0=add
min_o  out  7  game minutes
sec_o  out  6  game seconds
shot_o  out  6  shot clock seconds
period_o  out  3  current period, 1-based
score_a, score_b  out  8  scores
running  out  1  high in RUN
state_o  out  2  0=STOP, 1=RUN, 2=PER_END, 3=GAME_END
horn  out  1  horn drive

Behaviour:
- Reset values:
  - min_o=PERIOD_MIN, sec_o=0, shot_o=SHOT_SEC, period_o=1.
  - Scores 0, state STOP, running 0, horn 0.
  - All divider counters and button samples 0.
  - rst overrides everything, including a horn in progress.
- Scan and release detection:
  - Free-running scan counter 0..SCAN_DIV-1.
  - On terminal count, sample all buttons into registers and keep the previous sample.
  - A release is prev=1 and cur=0. It is a one-cycle event in the cycle after sampling.
  - A held button produces exactly one event.
- Tick generation:
  - Tick counter runs 0..TICK_DIV-1 only in RUN; it is held at 0 otherwise.
  - Tick is a one-cycle pulse at terminal count, so the first second after start is a full second.
- State machine:
  - STOP, release run → RUN. If shot_o==0, shot_o reloads SHOT_SEC in the same cycle.
  - RUN, release run → STOP. A tick in that same cycle is discarded.
  - RUN, tick → decrement the game clock: sec==0 gives sec=59, min-1; otherwise sec-1. shot_o decrements if nonzero.
  - If the new game time is 0:00 and period_o==NUM_PERIODS → GAME_END, horn.
  - If the new game time is 0:00 and period_o<NUM_PERIODS → PER_END, horn.
  - Else if the new shot_o==0 → STOP, horn. Game time end takes precedence over shot expiry.
  - PER_END, release run → RUN. Load min=PERIOD_MIN, sec=0, shot=SHOT_SEC, period+1.
  - GAME_END: left only by rst. The run and shot buttons are ignored.
- Shot reload:
  - Release of btn_shot sets shot_o=SHOT_SEC in STOP, RUN and PER_END.
  - In RUN it does not stop the clock.
  - If it coincides with a tick, the reload wins.
- Scoring:
  - Valid in every state, including GAME_END, so corrections remain possible.
  - If several btn_pts bits release in the same scan, only the highest weight applies (3>2>1).
  - The target team and sign are taken from sel_team/sel_sub in that cycle.
  - Add saturates: score = min(score+n, SCORE_MAX). Subtract floors: score = max(score−n, 0). There is never wrap-around.
- Horn:
  - A horn event loads a counter with HORN_CYC; horn=1 while the counter is nonzero.
  - A new event while sounding reloads the counter (retrigger).

Test Plan:
Parameters for all scenarios: TICK_DIV=4, SCAN_DIV=2, PERIOD_MIN=1, NUM_PERIODS=2, SHOT_SEC=5, HORN_CYC=3.
- Reset values: rst pulse → min_o=1, sec_o=0, shot_o=5, period_o=1, score_a=score_b=0, state_o=0, horn=0.
- Countdown and shot expiry: press/release btn_run → running=1, then 1:00→0:59 after 4 cycles. After 5 ticks shot_o=0, state_o=0, horn high exactly 3 cycles, min:sec=0:55.
- Restart after shot expiry: in the previous state release btn_run → shot_o=5, RUN. Releasing btn_shot at shot_o=2 → shot_o=5 and running stays 1.
- Period rollover: run to 0:00 → state_o=2, horn. Release run → period_o=2, 1:00, shot 5, RUN. Reaching 0:00 in period 2 → state_o=3, and btn_run is then ignored.
- Scoring saturation: sel_team=1, sel_sub=1, release 3 pt at score_a=1 → 0. With score_b=198, add 3 → 199. Releasing 1 pt and 3 pt together → +3 only.
- Mid-run reset: assert rst during RUN with horn active → all reset values next cycle, horn=0.
